// File: rtl/reg_demux_1x8.sv
// reg_demux_1x8: buffers {select, data} words in a small FIFO and delivers
// the head word to one of eight held channel registers (A..H) through a
// per-channel valid/ready handshake. Delivery is strictly in order.
module reg_demux_1x8 #(
  parameter int DEPTH = 2  // buffer entries, 2 or 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] InData,
  input  logic       Select0,
  input  logic       Select1,
  input  logic       Select2,
  input  logic       InValid,
  output logic       InReady,
  output logic [7:0] OutBus,
  output logic [7:0] OutValid,
  input  logic [7:0] OutReady,
  output logic [7:0] OutA,
  output logic [7:0] OutB,
  output logic [7:0] OutC,
  output logic [7:0] OutD,
  output logic [7:0] OutE,
  output logic [7:0] OutF,
  output logic [7:0] OutG,
  output logic [7:0] OutH
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Buffer entry layout: {select[2:0], data[7:0]}
  logic [10:0]      mem_q [DEPTH];
  logic [10:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [7:0]       ch_q [8];
  logic [7:0]       ch_d [8];

  logic [2:0] head_sel;
  logic [7:0] head_data;
  logic       not_empty;
  logic       push;
  logic       pop;

  assign not_empty             = (count_q != '0);
  assign {head_sel, head_data} = mem_q[rd_ptr_q];
  // InReady is a flop, so push never depends combinationally on OutReady.
  assign push                  = InValid & in_ready_q;
  // Only the ready bit of the channel the head is addressed to matters.
  assign pop                   = not_empty & OutReady[head_sel];

  assign InReady = in_ready_q;
  assign OutBus  = not_empty ? head_data : 8'h00;

  // One-hot destination decode of the head entry, all zero when empty.
  for (genvar gi = 0; gi < 8; gi++) begin : g_valid
    assign OutValid[gi] = not_empty & (head_sel == 3'(gi));
  end

  assign OutA = ch_q[0];
  assign OutB = ch_q[1];
  assign OutC = ch_q[2];
  assign OutD = ch_q[3];
  assign OutE = ch_q[4];
  assign OutF = ch_q[5];
  assign OutG = ch_q[6];
  assign OutH = ch_q[7];

  // Next-state: buffer write, pointer wrap, occupancy and channel update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ch_d     = ch_q;

    if (push) begin
      mem_d[wr_ptr_q] = {Select2, Select1, Select0, InData};
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      ch_d[head_sel] = head_data;
      rd_ptr_d       = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Registered so InReady is 0 throughout reset and rises on the first edge.
    in_ready_d = (count_d < DEPTH_C);
  end

  // State registers; reset discards buffered words and clears all channels.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 8; i++) ch_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      mem_q      <= mem_d;
      ch_q       <= ch_d;
    end
  end

endmodule

// File: tb/tb_reg_demux_1x8.sv
// Testbench for reg_demux_1x8: directed vectors, a queue-based reference
// model compared every cycle, and hand-computed literal expectations.
module tb_reg_demux_1x8;

  localparam int DEPTH = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] InData;
  logic       Select0, Select1, Select2;
  logic       InValid;
  logic       InReady;
  logic [7:0] OutBus;
  logic [7:0] OutValid;
  logic [7:0] OutReady;
  logic [7:0] OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH;

  int checks = 0;
  int errors = 0;

  reg_demux_1x8 #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InData(InData),
    .Select0(Select0), .Select1(Select1), .Select2(Select2),
    .InValid(InValid), .InReady(InReady), .OutBus(OutBus),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutA(OutA), .OutB(OutB), .OutC(OutC), .OutD(OutD),
    .OutE(OutE), .OutF(OutF), .OutG(OutG), .OutH(OutH)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {sel,data}, held channel values, ready flag.
  logic [10:0] mq[$];
  logic [7:0]  mch [8];
  logic        ready_m = 1'b0;
  bit          cmp_en = 1'b0;

  initial for (int i = 0; i < 8; i++) mch[i] = 8'h00;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mch[i] = 8'h00;
      ready_m = 1'b0;
    end else begin
      logic do_push, do_pop;
      logic [10:0] w;
      do_push = InValid && ready_m;
      do_pop  = (mq.size() > 0) && OutReady[mq[0][10:8]];
      if (do_pop) begin
        w = mq.pop_front();
        mch[w[10:8]] = w[7:0];
        $display("deliver ch%0d data=%0h at %0t", w[10:8], w[7:0], $time);
      end
      if (do_push) begin
        mq.push_back({Select2, Select1, Select0, InData});
        $display("accept  ch%0d data=%0h at %0t", {Select2, Select1, Select0}, InData, $time);
      end
      ready_m = (mq.size() < DEPTH);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (cmp_en) begin
      logic [7:0] ev, eb;
      ev = (mq.size() > 0) ? (8'h01 << mq[0][10:8]) : 8'h00;
      eb = (mq.size() > 0) ? mq[0][7:0] : 8'h00;
      chk("outvalid", {56'h0, OutValid}, {56'h0, ev});
      chk("outbus", {56'h0, OutBus}, {56'h0, eb});
      chk("inready", {63'h0, InReady}, {63'h0, ready_m});
      chk("channels", {OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH},
          {mch[0], mch[1], mch[2], mch[3], mch[4], mch[5], mch[6], mch[7]});
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s);
    InValid = v;
    InData  = d;
    {Select2, Select1, Select0} = s;
  endtask

  logic [7:0] stream_data [8];

  initial begin
    stream_data = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd0};
    Reset_n  = 1'b0;
    OutReady = 8'h00;
    drive(1'b0, 8'h00, 3'd0);
    #1;
    cmp_en = 1'b1;
    step();
    step();
    chk("reset_inready", {63'h0, InReady}, 64'h0);
    chk("reset_outvalid", {56'h0, OutValid}, 64'h0);
    Reset_n = 1'b1;
    #1;
    chk("release_inready_before_edge", {63'h0, InReady}, 64'h0);
    step();
    chk("release_inready_after_edge", {63'h0, InReady}, 64'h1);

    // Single word to channel D
    OutReady = 8'hFF;
    drive(1'b1, 8'd8, 3'd3);
    step();
    drive(1'b0, 8'h00, 3'd0);
    chk("single_outvalid", {56'h0, OutValid}, 64'h08);
    chk("single_outbus", {56'h0, OutBus}, 64'h08);
    step();
    chk("single_outvalid_after", {56'h0, OutValid}, 64'h00);
    chk("single_channels", {OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH},
        64'h00_00_00_08_00_00_00_00);

    // Back-pressure, full buffer, ignored third push
    OutReady = 8'h00;
    drive(1'b1, 8'd14, 3'd3);
    step();
    drive(1'b1, 8'd7, 3'd1);
    step();
    chk("full_inready", {63'h0, InReady}, 64'h0);
    drive(1'b1, 8'd99, 3'd5);
    step();
    drive(1'b0, 8'h00, 3'd0);
    chk("bp_head_valid", {56'h0, OutValid}, 64'h08);
    chk("bp_head_bus", {56'h0, OutBus}, 64'd14);
    OutReady = 8'h08;
    step();
    chk("bp_outd", {56'h0, OutD}, 64'd14);
    chk("bp_next_valid", {56'h0, OutValid}, 64'h02);
    chk("bp_next_bus", {56'h0, OutBus}, 64'd7);
    OutReady = 8'h02;
    step();
    chk("bp_outb", {56'h0, OutB}, 64'd7);
    chk("bp_empty_valid", {56'h0, OutValid}, 64'h00);

    // Wrong-channel ready leaves the head stable
    OutReady = 8'h00;
    drive(1'b1, 8'd3, 3'd4);
    step();
    drive(1'b0, 8'h00, 3'd0);
    OutReady = 8'hEF;
    step();
    step();
    chk("wrong_ready_valid", {56'h0, OutValid}, 64'h10);
    chk("wrong_ready_bus", {56'h0, OutBus}, 64'd3);
    chk("wrong_ready_oute", {56'h0, OutE}, 64'd0);
    OutReady = 8'h10;
    step();
    chk("right_ready_oute", {56'h0, OutE}, 64'd3);

    // Streaming, one word per cycle
    OutReady = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, stream_data[i], 3'(i));
      step();
    end
    drive(1'b0, 8'h00, 3'd0);
    step();
    step();
    chk("stream_channels", {OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH},
        64'h04_05_06_07_08_09_00_00);

    // Reset mid-operation with two words buffered
    OutReady = 8'h00;
    drive(1'b1, 8'h11, 3'd2);
    step();
    drive(1'b1, 8'h22, 3'd6);
    step();
    drive(1'b0, 8'h00, 3'd0);
    chk("prereset_valid", {56'h0, OutValid}, 64'h04);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {56'h0, OutValid}, 64'h00);
    chk("async_reset_bus", {56'h0, OutBus}, 64'h00);
    chk("async_reset_inready", {63'h0, InReady}, 64'h0);
    chk("async_reset_channels", {OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH}, 64'h0);
    step();
    Reset_n  = 1'b1;
    OutReady = 8'hFF;
    step();
    step();
    step();
    chk("post_reset_valid", {56'h0, OutValid}, 64'h00);
    chk("post_reset_channels", {OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH}, 64'h0);

    // Wrap-around: occupancy alternates 1 and 2, odd-cycle pushes hit a full buffer
    OutReady = 8'h00;
    drive(1'b1, 8'h40, 3'd0);
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h50 + i), 3'((i + 1) % 8));
      OutReady = (i % 2 == 0) ? 8'h00 : 8'hFF;
      step();
    end
    drive(1'b0, 8'h00, 3'd0);
    OutReady = 8'hFF;
    step();
    step();
    step();
    chk("wrap_channels", {OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH},
        64'h40_58_00_5A_00_54_00_56);
    chk("wrap_empty_valid", {56'h0, OutValid}, 64'h00);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
